seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Sequential signed restoring divider; the inverse companion of the shift-add multiplier.
//  Produces quotient and remainder of A / B, one quotient bit per clock, with a start/ready handshake.
//  Sits beside the multiplier in the arithmetic datapath and uses the same operand width parameter.
//  Results truncate toward zero, matching Verilog signed '/' and '%'.
// PARAMETERS
//  nb        15              operand width, two's complement; nb >= 2
//  req_bits  $clog2(nb)      iteration counter width is req_bits+1 (derived, do not override)
// PORTS
//  clk         in   1     rising-edge clock
//  rst_n       in   1     asynchronous active-low reset
//  start       in   1     load A,B and begin; sampled every edge, highest priority after reset
//  A           in   nb    signed dividend
//  B           in   nb    signed divisor
//  Quotient    out  nb    signed quotient, registered
//  Remainder   out  nb    signed remainder, registered; sign follows A
//  ready       out  1     result valid; high only in DONE
//  div_by_zero out  1     registered; valid when ready=1
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, counter=0, Quotient=0, Remainder=0,
//    ready=0, div_by_zero=0, internal regs cleared.
//  States: IDLE -> RUN -> FIX -> DONE. DONE holds until the next start. IDLE and DONE ignore A/B.
//  start=1 on any edge, in any state including RUN/FIX: capture |A|, |B|, qsign=A[nb-1]^B[nb-1],
//    rsign=A[nb-1]; clear rem (nb+1 b) and counter; load q=|A|; ready drops; div_by_zero=0.
//    Next state is RUN, or FIX if B==0.
//  Magnitudes: |x| = x[nb-1] ? ~x+1 : x, taken in nb bits unsigned. -2^(nb-1) maps to 2^(nb-1).
//  RUN, one iteration per edge: {rem,q} <= {rem,q} << 1; trial = rem_shifted - {1'b0,|B|};
//    if trial >= 0, then rem=trial and q[0]=1. counter++. After nb iterations (counter==nb-1 on that edge) -> FIX.
//  FIX (1 edge): Quotient  <= qsign ? ~q+1 : q
//                Remainder <= rsign ? ~rem[nb-1:0]+1 : rem[nb-1:0]; -> DONE, ready=1.
//  Latency: start edge E0; ready first high after edge E(nb+1); 16 cycles for nb=15.
//  B==0: skip RUN. FIX writes Quotient={nb{1'b1}}, Remainder=A (unmodified), div_by_zero=1.
//    Latency 2 edges.
//  Overflow: A=-2^(nb-1), B=-1 gives quotient magnitude 2^(nb-1), which wraps to -2^(nb-1).
//    Remainder=0. No flag is raised.
//  A=0: Quotient=0, Remainder=0. Negative zero cannot occur: negation of 0 is 0.
//  Quotient/Remainder change only on the FIX edge; they otherwise hold their last result, including during RUN.
//  Reset asserted mid-RUN: immediate return to reset values; the partial result is discarded.
// STRUCTURE
//  Package div_pkg: state typedef {IDLE, RUN, FIX, DONE} (2-bit encoding) and a function abs_nb().
//  Single module. The nb+1-bit trial subtractor stays inline, because one sub-module
//  (restoring_step) adds nothing at this size. One always_ff for state/datapath, one always_comb for trial.
// TESTING (nb=15, hex shown as 15-bit)
//  1 A=100,  B=7  -> ready after 16 edges; Quotient=14, Remainder=2, div_by_zero=0
//  2 A=-100, B=7  -> Quotient=-14 (7FF2), Remainder=-2 (7FFE); A=100,B=-7 -> Q=-14, R=2;
//    A=-100,B=-7 -> Q=14, R=-2
//  3 A=1234, B=0  -> ready after 2 edges; div_by_zero=1, Quotient=7FFF, Remainder=1234
//  4 A=4000 (-16384), B=7FFF (-1) -> Quotient=4000, Remainder=0; A=5, B=9 -> Q=0, R=5
//  5 start 100/7, re-assert start with 50/3 at edge 5 -> no ready until 16 edges after
//    second start; Q=16, R=2
//  6 rst_n low mid-RUN (edge 8) -> outputs 0 and ready=0 asynchronously; a new start after
//    release gives a correct result. Random signed sweep vs '/' '%' model, 10k vectors.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } div_state_e;

    localparam int unsigned AbsW = 64;

    // Caller sign-extends to AbsW and keeps the low nb bits, so -2^(nb-1) maps to 2^(nb-1).
    function automatic logic [AbsW-1:0] abs_nb(input logic [AbsW-1:0] x);
        return x[AbsW-1] ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Signed restoring divider, one quotient bit per clock, start/ready handshake.
// Results truncate toward zero; remainder takes the sign of the dividend.
module seq_divider
    import div_pkg::*;
#(
    parameter  int unsigned nb       = 15,
    localparam int unsigned req_bits = $clog2(nb)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [nb-1:0] A,
    input  logic signed [nb-1:0] B,
    output logic signed [nb-1:0] Quotient,
    output logic signed [nb-1:0] Remainder,
    output logic                 ready,
    output logic                 div_by_zero
);

    localparam int unsigned CntW = req_bits + 1;

    div_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    // Partial remainder is always below |B| <= 2^(nb-1), so nb bits hold it.
    logic [nb-1:0]   rem_q;
    logic [nb-1:0]   q_q;
    logic [nb-1:0]   b_abs_q;
    logic            qsign_q;
    logic            rsign_q;
    logic            bzero_q;

    logic [nb-1:0]   a_abs;
    logic [nb-1:0]   b_abs;
    logic [nb:0]     rem_shift;
    logic [nb:0]     trial;
    logic [nb-1:0]   q_neg;
    logic [nb-1:0]   rem_neg;

    always_comb begin
        a_abs     = nb'(abs_nb(AbsW'(A)));
        b_abs     = nb'(abs_nb(AbsW'(B)));
        rem_shift = {rem_q, q_q[nb-1]};
        trial     = rem_shift - {1'b0, b_abs_q};
        q_neg     = ~q_q + 1'b1;
        rem_neg   = ~rem_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            b_abs_q     <= '0;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            bzero_q     <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (start) begin
            state_q     <= (b_abs == '0) ? StFix : StRun;
            cnt_q       <= '0;
            rem_q       <= '0;
            q_q         <= a_abs;
            b_abs_q     <= b_abs;
            qsign_q     <= A[nb-1] ^ B[nb-1];
            rsign_q     <= A[nb-1];
            bzero_q     <= (b_abs == '0);
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                end
                StRun: begin
                    if (!trial[nb]) begin
                        rem_q <= trial[nb-1:0];
                        q_q   <= {q_q[nb-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_shift[nb-1:0];
                        q_q   <= {q_q[nb-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(nb - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    // With B==0 the dividend magnitude is still in q, so re-signing it yields A.
                    if (bzero_q) begin
                        Quotient  <= '1;
                        Remainder <= rsign_q ? q_neg : q_q;
                    end else begin
                        Quotient  <= qsign_q ? q_neg : q_q;
                        Remainder <= rsign_q ? rem_neg : rem_q;
                    end
                    div_by_zero <= bzero_q;
                    ready       <= 1'b1;
                    state_q     <= StDone;
                end
            endcase
        end
    end

endmodule
